mem_access_unit: RTL and testbench

- Load/store unit between the CPU MEM stage and the 64-bit byte-addressed data memory.
- Accepts one load or store per request and checks alignment and range.
- Loads: sign/zero-extends byte, half, word and double reads.
- Sub-doubleword stores: performs read-modify-write, because the memory always writes 8 bytes.
- Returns a single-cycle response pulse per request.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave is the unit's side; master is the CPU/memory side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [63:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_funct3,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment/range checks, load extension and
// read-modify-write for sub-doubleword stores on an 8-byte memory.
module mem_access_unit #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   io
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [63:0]       r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [63:0]       r_mem_wdata;
    logic [63:0]       r_resp_rdata;
    logic              r_resp_err;

    logic w_accept;
    logic w_f3_ok;
    logic w_align_ok;
    logic w_range_ok;
    logic w_err;
    logic w_is_sd;

    function automatic logic [63:0] f_extend(
        input logic [2:0]  f3,
        input logic [63:0] d
    );
        logic [63:0] v;
        case (f3)
            3'b000:  v = {{56{d[7]}}, d[7:0]};
            3'b001:  v = {{48{d[15]}}, d[15:0]};
            3'b010:  v = {{32{d[31]}}, d[31:0]};
            3'b100:  v = {56'd0, d[7:0]};
            3'b101:  v = {48'd0, d[15:0]};
            3'b110:  v = {32'd0, d[31:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    // Old memory contents keep the bytes the store does not cover.
    function automatic logic [63:0] f_merge(
        input logic [2:0]  f3,
        input logic [63:0] rd,
        input logic [63:0] wd
    );
        logic [63:0] v;
        case (f3)
            3'b000:  v = {rd[63:8], wd[7:0]};
            3'b001:  v = {rd[63:16], wd[15:0]};
            3'b010:  v = {rd[63:32], wd[31:0]};
            default: v = wd;
        endcase
        return v;
    endfunction

    assign w_accept = (r_state == S_IDLE) && io.req_valid;
    assign w_f3_ok  = io.req_write ? ~io.req_funct3[2]
                                   : (io.req_funct3 != 3'b111);
    assign w_range_ok = (io.req_addr <= LP_MAX_ADDR);
    assign w_err    = ~(w_f3_ok & w_align_ok & w_range_ok);
    assign w_is_sd  = io.req_write && (io.req_funct3 == 3'b011);

    always_comb begin
        w_align_ok = 1'b1;
        case (io.req_funct3[1:0])
            2'b01:   w_align_ok = ~io.req_addr[0];
            2'b10:   w_align_ok = ~|io.req_addr[1:0];
            2'b11:   w_align_ok = ~|io.req_addr[2:0];
            default: w_align_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (1'b1)
            (r_state == S_IDLE): begin
                if (io.req_valid) begin
                    if (w_err) begin
                        w_next = S_RESP;
                    end else if (w_is_sd) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            (r_state == S_READ):  w_next = r_write ? S_WRITE : S_RESP;
            (r_state == S_WRITE): w_next = S_RESP;
            (r_state == S_RESP):  w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
    end

    always_comb begin
        io.req_ready  = (r_state == S_IDLE);
        io.mem_read   = (r_state == S_READ);
        io.mem_write  = (r_state == S_WRITE);
        io.resp_valid = (r_state == S_RESP);
        io.mem_addr   = r_mem_addr;
        io.mem_wdata  = r_mem_wdata;
        io.resp_rdata = r_resp_rdata;
        io.resp_err   = r_resp_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_wdata      <= 64'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 64'd0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write  <= io.req_write;
                        r_funct3 <= io.req_funct3;
                        r_wdata  <= io.req_wdata;
                        if (w_err) begin
                            r_resp_rdata <= 64'd0;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_mem_addr <= io.req_addr;
                            if (w_is_sd) begin
                                r_mem_wdata <= io.req_wdata;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (r_write) begin
                        r_mem_wdata <= f_merge(r_funct3, io.mem_rdata, r_wdata);
                    end else begin
                        r_resp_rdata <= f_extend(r_funct3, io.mem_rdata);
                        r_resp_err   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_resp_rdata <= 64'd0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus
// a reset-during-store sequence against a byte-array memory.
module tb_mem_access_unit;
    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic loaded = 1'b0;
    logic [7:0] dm [64];
    int tests = 0;
    int fails = 0;
    int overlap = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(64)) bus();

    mem_access_unit #(
        .MEM_BYTES(64),
        .ADDR_W(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(bus.slave)
    );

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_rdata[8*i +: 8] = dm[(int'(bus.mem_addr[5:0]) + i) % 64];
        end
    end

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) dm[i] <= 8'(i + 2);
            loaded <= 1'b1;
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++) begin
                dm[(int'(bus.mem_addr[5:0]) + i) % 64] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee,
                       input int lat, input int nrd, input int nwr);
        vec_t v;
        v.name = nm; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
        v.exp_rd = nrd; v.exp_wr = nwr;
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int nrd;
        int nwr;
        logic [63:0] held;
        wait_ready();
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk({v.name, " ready_low"}, 64'(bus.req_ready), 64'd0);
        lat = 0; nrd = 0; nwr = 0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.mem_read) nrd++;
            if (bus.mem_write) nwr++;
            if (bus.mem_read && bus.mem_write) overlap++;
            if (bus.resp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({v.name, " rdata"}, bus.resp_rdata, v.exp_rdata);
        chk({v.name, " err"}, 64'(bus.resp_err), 64'(v.exp_err));
        chk({v.name, " reads"}, 64'(nrd), 64'(v.exp_rd));
        chk({v.name, " writes"}, 64'(nwr), 64'(v.exp_wr));
        held = bus.resp_rdata;
        @(posedge clk);
        #1;
        chk({v.name, " pulse"}, 64'(bus.resp_valid), 64'd0);
        chk({v.name, " hold"}, bus.resp_rdata, held);
    endtask

    initial begin
        vec_t lv;
        int bad;
        logic [63:0] word;

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0;

        add("ld8",     0, 3'b011, 8,  0, 64'h11100F0E0D0C0B0A, 0, 2, 1, 0);
        add("sb16",    1, 3'b000, 16, 64'hFF, 0, 0, 3, 1, 1);
        add("ld16",    0, 3'b011, 16, 0, 64'h19181716151413FF, 0, 2, 1, 0);
        add("lb16",    0, 3'b000, 16, 0, 64'hFFFFFFFFFFFFFFFF, 0, 2, 1, 0);
        add("lbu16",   0, 3'b100, 16, 0, 64'h00000000000000FF, 0, 2, 1, 0);
        add("lw56",    0, 3'b010, 56, 0, 64'h000000003D3C3B3A, 0, 2, 1, 0);
        add("lh9",     0, 3'b001, 9,  0, 0, 1, 1, 0, 0);
        add("ld64",    0, 3'b011, 64, 0, 0, 1, 1, 0, 0);
        add("lw60",    0, 3'b010, 60, 0, 0, 1, 1, 0, 0);
        add("st100",   1, 3'b100, 0,  64'h55, 0, 1, 1, 0, 0);
        add("ld111",   0, 3'b111, 0,  0, 0, 1, 1, 0, 0);
        add("sb63",    1, 3'b000, 63, 64'h77, 0, 1, 1, 0, 0);
        add("sd0",     1, 3'b011, 0,  64'h0123456789ABCDEF, 0, 0, 2, 0, 1);
        add("ld0",     0, 3'b011, 0,  0, 64'h0123456789ABCDEF, 0, 2, 1, 0);
        add("sh24",    1, 3'b001, 24, 64'h123456789ABCBEEF, 0, 0, 3, 1, 1);
        add("ld24",    0, 3'b011, 24, 0, 64'h21201F1E1D1CBEEF, 0, 2, 1, 0);
        add("lh24",    0, 3'b001, 24, 0, 64'hFFFFFFFFFFFFBEEF, 0, 2, 1, 0);
        add("lhu26",   0, 3'b101, 26, 0, 64'h0000000000001D1C, 0, 2, 1, 0);
        add("sw32",    1, 3'b010, 32, 64'hFFFFFFFF80000000, 0, 0, 3, 1, 1);
        add("ld32",    0, 3'b011, 32, 0, 64'h2928272680000000, 0, 2, 1, 0);
        add("lw32",    0, 3'b010, 32, 0, 64'hFFFFFFFF80000000, 0, 2, 1, 0);
        add("lwu32",   0, 3'b110, 32, 0, 64'h0000000080000000, 0, 2, 1, 0);
        add("ld56",    0, 3'b011, 56, 0, 64'h41403F3E3D3C3B3A, 0, 2, 1, 0);

        #2 reset = 1'b1;
        #2;
        chk("rst ready", 64'(bus.req_ready), 64'd1);
        chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst mem_read", 64'(bus.mem_read), 64'd0);
        chk("rst mem_write", 64'(bus.mem_write), 64'd0);
        chk("rst mem_addr", bus.mem_addr, 64'd0);
        chk("rst rdata", bus.resp_rdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset lands while an sw is in its read phase.
        wait_ready();
        bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 40; bus.req_wdata = 64'hAAAAAAAAAAAAAAAA;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("midrst in_read", 64'(bus.mem_read), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst ready", 64'(bus.req_ready), 64'd1);
        chk("midrst resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("midrst mem_read", 64'(bus.mem_read), 64'd0);
        chk("midrst mem_write", 64'(bus.mem_write), 64'd0);
        chk("midrst mem_addr", bus.mem_addr, 64'd0);
        chk("midrst mem_wdata", bus.mem_wdata, 64'd0);
        chk("midrst rdata", bus.resp_rdata, 64'd0);
        chk("midrst err", 64'(bus.resp_err), 64'd0);
        bad = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.mem_write || bus.resp_valid) bad++;
        end
        @(negedge clk) reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.mem_write || bus.resp_valid) bad++;
        end
        chk("midrst no_activity", 64'(bad), 64'd0);
        for (int i = 0; i < 8; i++) word[8*i +: 8] = dm[40 + i];
        chk("midrst mem40", word, 64'h31302F2E2D2C2B2A);

        lv.name = "ld40"; lv.wr = 0; lv.f3 = 3'b011; lv.addr = 40;
        lv.wdata = 0; lv.exp_rdata = 64'h31302F2E2D2C2B2A; lv.exp_err = 0;
        lv.exp_lat = 2; lv.exp_rd = 1; lv.exp_wr = 0;
        run_vec(lv);

        chk("rd_wr_overlap", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
